// File: rtl/fetch_pkg.sv
// fetch_pkg: shared sizes, FIFO entry type and PC helpers
// for the instruction fetch stage.
package fetch_pkg;

   localparam int WIDTH = 32;
   localparam int DEPTH = 128;
   localparam int AW    = $clog2(DEPTH);

   typedef struct packed {
      logic [WIDTH-1:0] instr;
      logic [AW-1:0]    pc;
   } fetch_entry_t;

   function automatic logic [AW-1:0] pc_inc(input logic [AW-1:0] pc);
      return (pc == AW'(DEPTH - 1)) ? '0 : pc + 1'b1;
   endfunction

   function automatic logic [AW-1:0] pc_clamp(input logic [AW-1:0] pc);
      logic [AW:0] wide;
      wide = {1'b0, pc} % (AW + 1)'(DEPTH);
      return wide[AW-1:0];
   endfunction

endpackage

// File: rtl/fetch_skid_fifo.sv
// fetch_skid_fifo: 2-entry {instr, pc} buffer between the
// memory return path and decode; flush empties it at once.
module fetch_skid_fifo
   import fetch_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  fetch_entry_t push_data,
   input  logic         pop,
   input  logic         flush,
   output fetch_entry_t head,
   output logic [1:0]   count
);

   fetch_entry_t [1:0] mem_q, mem_d;
   logic               rd_ptr_q, rd_ptr_d;
   logic               wr_ptr_q, wr_ptr_d;
   logic [1:0]         count_q, count_d;

   assign head  = mem_q[rd_ptr_q];
   assign count = count_q;

   // Pointer/occupancy update; flush overrides push and pop.
   always_comb begin
      mem_d    = mem_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush) begin
         rd_ptr_d = 1'b0;
         wr_ptr_d = 1'b0;
         count_d  = 2'd0;
      end else begin
         if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ~wr_ptr_q;
         end
         if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
         end
         count_d = count_q + 2'(push) - 2'(pop);
      end
   end

   // Storage and pointers; reset clears entries so the head reads zero.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem_q    <= '0;
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         mem_q    <= mem_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: drives the memory read port with the PC, tracks one
// outstanding read and hands words to decode; redirect flushes all.
module instr_fetch
   import fetch_pkg::*;
#(
   parameter logic [AW-1:0] RESET_PC = '0
)
(
   input  logic             clk,
   input  logic             rst,
   output logic [AW-1:0]    mem_rd_addr,
   input  logic [WIDTH-1:0] mem_rd_data,
   output logic             if_valid,
   input  logic             if_ready,
   output logic [WIDTH-1:0] if_instr,
   output logic [AW-1:0]    if_pc,
   input  logic             redirect_valid,
   input  logic [AW-1:0]    redirect_pc
);

   logic [AW-1:0] pc_q, pc_d;
   logic          infl_v_q, infl_v_d;
   logic [AW-1:0] infl_pc_q, infl_pc_d;

   logic          pop, push, issue;
   logic [1:0]    fifo_count;
   logic [2:0]    occ;
   fetch_entry_t  push_ent, head;

   assign mem_rd_addr = pc_q;
   assign if_valid    = (fifo_count != 2'd0);
   assign pop         = if_valid & if_ready;
   assign push        = infl_v_q & ~redirect_valid;
   assign occ         = 3'(fifo_count) + 3'(infl_v_q) - 3'(pop);
   assign issue       = ~redirect_valid & (occ < 3'd2);
   assign push_ent    = '{instr: mem_rd_data, pc: infl_pc_q};
   assign if_instr    = head.instr;
   assign if_pc       = head.pc;

   fetch_skid_fifo u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (push_ent),
      .pop       (pop),
      .flush     (redirect_valid),
      .head      (head),
      .count     (fifo_count)
   );

   // Next PC and in-flight tracking; redirect beats issue.
   always_comb begin
      pc_d      = pc_q;
      infl_v_d  = infl_v_q;
      infl_pc_d = infl_pc_q;
      if (redirect_valid) begin
         pc_d     = pc_clamp(redirect_pc);
         infl_v_d = 1'b0;
      end else if (issue) begin
         pc_d      = pc_inc(pc_q);
         infl_v_d  = 1'b1;
         infl_pc_d = pc_q;
      end else begin
         infl_v_d = 1'b0;
      end
   end

   // PC and outstanding-read registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_q      <= RESET_PC;
         infl_v_q  <= 1'b0;
         infl_pc_q <= '0;
      end else begin
         pc_q      <= pc_d;
         infl_v_q  <= infl_v_d;
         infl_pc_q <= infl_pc_d;
      end
   end

   a_no_push_full : assert property (
      @(posedge clk) disable iff (!rst)
      !(push && fifo_count == 2'd2));

   a_redirect_range : assert property (
      @(posedge clk) disable iff (!rst)
      !(redirect_valid && {1'b0, redirect_pc} >= (AW + 1)'(DEPTH)));

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed and random stimulus for instr_fetch,
// checked against a transaction-level model of the fetch stream.
module tb_instr_fetch;
   import fetch_pkg::*;

   logic             clk = 1'b0;
   logic             rst;
   logic [AW-1:0]    mem_rd_addr;
   logic [WIDTH-1:0] mem_rd_data;
   logic             if_valid;
   logic             if_ready;
   logic [WIDTH-1:0] if_instr;
   logic [AW-1:0]    if_pc;
   logic             redirect_valid;
   logic [AW-1:0]    redirect_pc;

   int checks = 0;
   int errors = 0;

   int exp_pc = 0;
   int age = 0;
   int seen[$];

   instr_fetch dut (
      .clk            (clk),
      .rst            (rst),
      .mem_rd_addr    (mem_rd_addr),
      .mem_rd_data    (mem_rd_data),
      .if_valid       (if_valid),
      .if_ready       (if_ready),
      .if_instr       (if_instr),
      .if_pc          (if_pc),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc)
   );

   always #5 clk = ~clk;

   always_ff @(posedge clk)
      mem_rd_data <= 32'hA000_0000 + 32'(mem_rd_addr);

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      logic [31:0] exp_instr;
      @(negedge clk);
      if (!rst) begin
         chk("rst_valid", 64'(if_valid), 64'd0);
         chk("rst_instr", 64'(if_instr), 64'd0);
         chk("rst_pc", 64'(if_pc), 64'd0);
         chk("rst_addr", 64'(mem_rd_addr), 64'd0);
         exp_pc = 0;
         age    = 0;
      end else begin
         chk("valid", 64'(if_valid), 64'(age >= 2));
         if (age >= 2) begin
            exp_instr = 32'hA000_0000 + 32'(exp_pc);
            chk("pc", 64'(if_pc), 64'(exp_pc));
            chk("instr", 64'(if_instr), 64'(exp_instr));
            if (if_ready) begin
               seen.push_back(int'(if_pc));
               exp_pc = (exp_pc + 1) % DEPTH;
            end
         end
         if (redirect_valid) begin
            exp_pc = int'(redirect_pc);
            age    = 0;
         end else begin
            age++;
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      int i;
      rst            = 1'b0;
      if_ready       = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = '0;

      tick();
      tick();
      rst = 1'b1;

      for (i = 0; i < 20 && !(if_valid && if_pc == 7'd4); i++) tick();
      chk("reach_pc4", 64'(if_valid && if_pc == 7'd4), 64'd1);

      if_ready = 1'b0;
      repeat (5) tick();
      chk("stall_count", 64'(dut.u_fifo.count), 64'd2);
      chk("stall_addr", 64'(mem_rd_addr), 64'd6);
      chk("stall_pc", 64'(if_pc), 64'd4);
      seen.delete();
      if_ready = 1'b1;
      repeat (4) tick();
      chk("resume_n", 64'(seen.size()), 64'd4);
      chk("resume_0", 64'(seen[0]), 64'd4);
      chk("resume_3", 64'(seen[3]), 64'd7);

      for (i = 0; i < 20 && !(if_valid && if_pc == 7'd10); i++) tick();
      chk("reach_pc10", 64'(if_valid && if_pc == 7'd10), 64'd1);
      redirect_valid = 1'b1;
      redirect_pc    = 7'd100;
      tick();
      redirect_valid = 1'b0;
      seen.delete();
      tick();
      tick();
      chk("redir_lat_v", 64'(if_valid), 64'd1);
      chk("redir_lat_pc", 64'(if_pc), 64'd100);
      tick();
      chk("redir_first", 64'(seen[0]), 64'd100);

      redirect_valid = 1'b1;
      redirect_pc    = 7'd126;
      tick();
      redirect_valid = 1'b0;
      seen.delete();
      repeat (6) tick();
      chk("wrap_n", 64'(seen.size() >= 4), 64'd1);
      chk("wrap_0", 64'(seen[0]), 64'd126);
      chk("wrap_1", 64'(seen[1]), 64'd127);
      chk("wrap_2", 64'(seen[2]), 64'd0);
      chk("wrap_3", 64'(seen[3]), 64'd1);

      if_ready = 1'b0;
      repeat (3) tick();
      chk("full_count", 64'(dut.u_fifo.count), 64'd2);
      redirect_valid = 1'b1;
      redirect_pc    = 7'd40;
      tick();
      redirect_pc    = 7'd60;
      tick();
      redirect_valid = 1'b0;
      seen.delete();
      if_ready = 1'b1;
      repeat (5) tick();
      chk("dbl_redir", 64'(seen[0]), 64'd60);

      if_ready = 1'b0;
      repeat (4) tick();
      chk("pre_rst_cnt", 64'(dut.u_fifo.count), 64'd2);
      rst = 1'b0;
      #1;
      chk("async_valid", 64'(if_valid), 64'd0);
      chk("async_addr", 64'(mem_rd_addr), 64'd0);
      tick();
      rst      = 1'b1;
      if_ready = 1'b1;
      seen.delete();
      repeat (5) tick();
      chk("restart_0", 64'(seen[0]), 64'd0);
      chk("restart_1", 64'(seen[1]), 64'd1);

      for (int n = 0; n < 400; n++) begin
         if_ready       = ($urandom % 4) != 0;
         redirect_valid = ($urandom % 16) == 0;
         redirect_pc    = 7'($urandom_range(0, DEPTH - 1));
         tick();
      end
      redirect_valid = 1'b0;
      if_ready       = 1'b1;
      repeat (4) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
